// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and counter sizing.
package reset_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_SETTLE    = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RUN       = 3'd3,
      ST_PLL_RST   = 3'd4
   } state_t;

   // Width that holds the largest cycle parameter with headroom, so no state can wrap.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer with synchronous active-low reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged downstream reset release gated by a stable PLL lock.
// Optional PLL-reset retry on lock timeout: define RESET_SEQUENCER_TIMEOUT_EN.
//
// state        | meaning
// WAIT_LOCK    | all stages held in reset, waiting for synchronized lock
// SETTLE       | lock seen, counting stable cycles before first release
// RELEASE      | releasing stages one by one, STAGE_DELAY_CYCLES apart
// RUN          | all stages released; accepts resequence requests
// PLL_RST      | pulsing pll_reset after a lock timeout (timeout build only)
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_STAGES         = 4,
   parameter int LOCK_STABLE_CYCLES = 500000,
   parameter int STAGE_DELAY_CYCLES = 16,
   parameter int TIMEOUT_CYCLES     = 1000000,
   parameter int PLL_RESET_CYCLES   = 8
) (
   input  logic                  upstream_clock,
   input  logic                  upstream_reset_n,
   input  logic                  pll_locked,
   input  logic                  resequence_request,
   output logic                  resequence_ack,
   output logic [NUM_STAGES-1:0] downstream_reset,
   output logic                  sequence_done,
   output logic                  pll_reset,
   output logic [7:0]            retry_count
);

   localparam int CW = cnt_width(LOCK_STABLE_CYCLES, STAGE_DELAY_CYCLES,
                                 TIMEOUT_CYCLES, PLL_RESET_CYCLES);
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CW-1:0] SETTLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] STAGE_LAST  = CW'(STAGE_DELAY_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_STAGES - 1);

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [IW-1:0]           idx_q;
   logic [NUM_STAGES-1:0]   ds_q;
   logic                    done_q;
   logic                    ack_q;
   logic                    lock_s;

   sync_2ff u_lock_sync (
      .clk_i   (upstream_clock),
      .rst_n_i (upstream_reset_n),
      .d_i     (pll_locked),
      .q_o     (lock_s)
   );

`ifdef RESET_SEQUENCER_TIMEOUT_EN
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] PR_LAST = CW'(PLL_RESET_CYCLES - 1);

   logic [CW-1:0] tcnt_q;
   logic [CW-1:0] pcnt_q;
   logic          pll_rst_q;
   logic [7:0]    retry_q;
`endif

   always_ff @(posedge upstream_clock) begin
      if (!upstream_reset_n) begin
         state_q <= ST_WAIT_LOCK;
         cnt_q   <= '0;
         idx_q   <= '0;
         ds_q    <= '1;
         done_q  <= 1'b0;
         ack_q   <= 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
         tcnt_q    <= '0;
         pcnt_q    <= '0;
         pll_rst_q <= 1'b0;
         retry_q   <= '0;
`endif
      end else begin
         ack_q <= 1'b0;
         // Lock loss outranks everything, including a same-cycle resequence request.
         if (!lock_s && (state_q == ST_SETTLE || state_q == ST_RELEASE || state_q == ST_RUN)) begin
            state_q <= ST_WAIT_LOCK;
            ds_q    <= '1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
         end else begin
            case (state_q)
               ST_WAIT_LOCK: begin
                  ds_q   <= '1;
                  done_q <= 1'b0;
                  if (lock_s) begin
                     state_q <= ST_SETTLE;
                     cnt_q   <= '0;
                  end
               end
               ST_SETTLE: begin
                  if (cnt_q == SETTLE_LAST) begin
                     state_q <= ST_RELEASE;
                     cnt_q   <= '0;
                     idx_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               ST_RELEASE: begin
                  if (cnt_q == STAGE_LAST) begin
                     cnt_q       <= '0;
                     ds_q[idx_q] <= 1'b0;
                     if (idx_q == IDX_LAST) begin
                        state_q <= ST_RUN;
                        done_q  <= 1'b1;
                     end else begin
                        idx_q <= idx_q + IW'(1);
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               ST_RUN: begin
                  if (resequence_request) begin
                     ack_q   <= 1'b1;
                     ds_q    <= '1;
                     done_q  <= 1'b0;
                     state_q <= ST_RELEASE;
                     cnt_q   <= '0;
                     idx_q   <= '0;
                  end else begin
                     ds_q <= '0;
                  end
               end
`ifdef RESET_SEQUENCER_TIMEOUT_EN
               ST_PLL_RST: begin
                  if (pcnt_q == PR_LAST) begin
                     pll_rst_q <= 1'b0;
                     state_q   <= ST_WAIT_LOCK;
                  end else begin
                     pcnt_q <= pcnt_q + CW'(1);
                  end
               end
`endif
               default: state_q <= ST_WAIT_LOCK;
            endcase
         end

`ifdef RESET_SEQUENCER_TIMEOUT_EN
         // The timeout spans lock glitches; only reaching RELEASE or firing clears it.
         if (state_q == ST_WAIT_LOCK || state_q == ST_SETTLE) begin
            if (tcnt_q == TO_LAST) begin
               state_q   <= ST_PLL_RST;
               pll_rst_q <= 1'b1;
               pcnt_q    <= '0;
               tcnt_q    <= '0;
               cnt_q     <= '0;
               ds_q      <= '1;
               done_q    <= 1'b0;
               if (retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
            end else if (state_q == ST_SETTLE && lock_s && cnt_q == SETTLE_LAST) begin
               tcnt_q <= '0;
            end else begin
               tcnt_q <= tcnt_q + CW'(1);
            end
         end
`endif
      end
   end

   assign resequence_ack   = ack_q;
   assign downstream_reset = ds_q;
   assign sequence_done    = done_q;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
   assign pll_reset   = pll_rst_q;
   assign retry_count = retry_q;
`else
   assign pll_reset   = 1'b0;
   assign retry_count = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small cycle parameters.
`timescale 1ns/1ps
module tb_reset_sequencer;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       req;
   logic       ack;
   logic [2:0] ds;
   logic       done;
   logic       pll_rst;
   logic [7:0] retry;

   int n_total = 0;
   int n_bad   = 0;
   int viol    = 0;
   logic [2:0] prev_ds = 3'b111;

   reset_sequencer #(
      .NUM_STAGES         (3),
      .LOCK_STABLE_CYCLES (10),
      .STAGE_DELAY_CYCLES (4),
      .TIMEOUT_CYCLES     (50),
      .PLL_RESET_CYCLES   (3)
   ) dut (
      .upstream_clock     (clk),
      .upstream_reset_n   (rst_n),
      .pll_locked         (locked),
      .resequence_request (req),
      .resequence_ack     (ack),
      .downstream_reset   (ds),
      .sequence_done      (done),
      .pll_reset          (pll_rst),
      .retry_count        (retry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A released stage may only come back as part of an all-ones re-assert.
   always @(negedge clk) begin
      if (((ds & ~prev_ds) != 3'b000) && (ds != 3'b111)) viol++;
      prev_ds = ds;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic acks_seen;

      // power-on: reset for 5 cycles, lock from cycle 20
      rst_n = 1'b0; locked = 1'b0; req = 1'b0;
      tick(5);
      check("rst_ds",    32'(ds),      32'h7);
      check("rst_done",  32'(done),    32'h0);
      check("rst_ack",   32'(ack),     32'h0);
      check("rst_pll",   32'(pll_rst), 32'h0);
      check("rst_retry", 32'(retry),   32'h0);
      rst_n = 1'b1;
      tick(15);
      locked = 1'b1;
      tick(16);
      check("po_hold",   32'(ds),   32'h7);
      tick(1);
      check("po_rel0",   32'(ds),   32'h6);
      tick(3);
      check("po_rel0b",  32'(ds),   32'h6);
      check("po_done0",  32'(done), 32'h0);
      tick(1);
      check("po_rel1",   32'(ds),   32'h4);
      tick(3);
      check("po_done1",  32'(done), 32'h0);
      tick(1);
      check("po_rel2",   32'(ds),   32'h0);
      check("po_done",   32'(done), 32'h1);

      // reset mid-run aborts on the next edge
      rst_n = 1'b0; locked = 1'b0;
      tick(1);
      check("abort_ds",   32'(ds),   32'h7);
      check("abort_done", 32'(done), 32'h0);
      tick(2);
      rst_n = 1'b1;

      // lock glitch in SETTLE restarts the full settle
      locked = 1'b1;
      tick(5);
      locked = 1'b0;
      tick(2);
      locked = 1'b1;
      tick(10);
      check("gl_noearly", 32'(ds), 32'h7);
      tick(6);
      check("gl_hold",    32'(ds), 32'h7);
      tick(1);
      check("gl_rel0",    32'(ds), 32'h6);
      tick(8);
      check("gl_ds",      32'(ds),   32'h0);
      check("gl_done",    32'(done), 32'h1);

      // lock loss in RUN
      locked = 1'b0;
      tick(2);
      check("ll_still",  32'(ds),   32'h0);
      tick(1);
      check("ll_ds",     32'(ds),   32'h7);
      check("ll_done",   32'(done), 32'h0);
      locked = 1'b1;
      tick(16);
      check("ll_hold",   32'(ds),   32'h7);
      tick(1);
      check("ll_rel0",   32'(ds),   32'h6);
      tick(8);
      check("ll_ds2",    32'(ds),   32'h0);
      check("ll_done2",  32'(done), 32'h1);

      // resequence from RUN skips settle
      req = 1'b1;
      tick(1);
      check("rq_ack",    32'(ack),  32'h1);
      check("rq_ds",     32'(ds),   32'h7);
      check("rq_done",   32'(done), 32'h0);
      req = 1'b0;
      tick(1);
      check("rq_ack1",   32'(ack),  32'h0);
      tick(1);
      req = 1'b1;
      acks_seen = 1'b0;
      for (int i = 4; i <= 13; i++) begin
         tick(1);
         if (ack) acks_seen = 1'b1;
         if (i == 5) check("rq_rel0", 32'(ds), 32'h6);
      end
      check("rq_noack_rel", 32'(acks_seen), 32'h0);
      check("rq_ds_run",    32'(ds),        32'h0);
      check("rq_done_run",  32'(done),      32'h1);
      tick(1);
      check("rq_ack_run",   32'(ack), 32'h1);
      check("rq_ds2",       32'(ds),  32'h7);
      req = 1'b0;
      tick(1);
      check("rq_ack_off",   32'(ack), 32'h0);
      tick(11);
      check("rq_ds3",       32'(ds),   32'h0);
      check("rq_done3",     32'(done), 32'h1);

      // request coinciding with lock loss: lock loss wins
      locked = 1'b0;
      tick(2);
      req = 1'b1;
      tick(1);
      check("co_ack",  32'(ack),  32'h0);
      check("co_ds",   32'(ds),   32'h7);
      check("co_done", 32'(done), 32'h0);
      acks_seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         if (ack) acks_seen = 1'b1;
      end
      check("co_noack", 32'(acks_seen), 32'h0);
      req = 1'b0;
      locked = 1'b1;
      tick(16);
      check("co_settle", 32'(ds), 32'h7);
      tick(1);
      check("co_rel0",   32'(ds), 32'h6);

`ifdef RESET_SEQUENCER_TIMEOUT_EN
      // lock stuck low: PLL reset pulses every 53 cycles
      rst_n = 1'b0; locked = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(49);
      check("to_pre",    32'(pll_rst), 32'h0);
      tick(1);
      check("to_p1",     32'(pll_rst), 32'h1);
      check("to_retry1", 32'(retry),   32'h1);
      tick(2);
      check("to_p3",     32'(pll_rst), 32'h1);
      tick(1);
      check("to_end",    32'(pll_rst), 32'h0);
      tick(49);
      check("to_pre2",   32'(pll_rst), 32'h0);
      tick(1);
      check("to_p2",     32'(pll_rst), 32'h1);
      check("to_retry2", 32'(retry),   32'h2);
`else
      // lock stuck low without timeout support: no PLL reset ever
      rst_n = 1'b0; locked = 1'b0;
      tick(3);
      rst_n = 1'b1;
      acks_seen = 1'b0;
      for (int i = 0; i < 120; i++) begin
         tick(1);
         if (pll_rst) acks_seen = 1'b1;
      end
      check("nto_pll",   32'(acks_seen), 32'h0);
      check("nto_retry", 32'(retry),     32'h0);
      check("nto_ds",    32'(ds),        32'h7);
`endif

      check("no_reassert", 32'(viol), 32'h0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of downstream reset domains, released in index order.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 500000: cycles pll lock must hold before the first release (0.05 s at 10 MHz).
REQ-003 Parameter STAGE_DELAY_CYCLES, default 16: cycles between consecutive stage releases.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000000: cycles without stable lock before a PLL reset pulse (timeout feature only).
REQ-005 Parameter PLL_RESET_CYCLES, default 8: width of the pll_reset pulse (timeout feature only).
REQ-006 upstream_clock  in  1  the only clock; all logic on its rising edge.
REQ-007 upstream_reset_n  in  1  synchronous, active-low reset.
REQ-008 pll_locked  in  1  asynchronous lock indication from the downstream PLL.
REQ-009 resequence_request  in  1  level request to re-run the release sequence; requester holds it until acked.
REQ-010 resequence_ack  out  1  one-cycle pulse on acceptance of resequence_request.
REQ-011 downstream_reset  out  NUM_STAGES  active-high per-stage resets; bit 0 released first.
REQ-012 sequence_done  out  1  high while all stages are released.
REQ-013 pll_reset  out  1  active-high PLL reset pulse.
REQ-014 retry_count  out  8  number of timeout-triggered PLL resets, saturating at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; lock_s is its output, used everywhere else.
REQ-016 States: WAIT_LOCK, SETTLE, RELEASE, RUN, PLL_RST (PLL_RST is reachable only with the timeout feature).
REQ-017 WAIT_LOCK: all downstream_reset bits 1, sequence_done 0; go to SETTLE with cnt=0 when lock_s=1.
REQ-018 SETTLE: cnt increments while lock_s=1; lock_s=0 returns to WAIT_LOCK; at cnt==LOCK_STABLE_CYCLES-1, go to RELEASE with idx=0, cnt=0.
REQ-019 RELEASE: cnt counts to STAGE_DELAY_CYCLES-1, then downstream_reset[idx]<=0 and cnt=0.
  - If idx==NUM_STAGES-1, go to RUN and set sequence_done<=1 in the same cycle; otherwise idx increments.
REQ-020 RUN: hold all downstream_reset bits at 0.
REQ-021 lock_s=0 in SETTLE, RELEASE or RUN: downstream_reset<=all 1, sequence_done<=0, next state WAIT_LOCK, counters cleared.
REQ-022 resequence_request=1 sampled in RUN: resequence_ack=1 for one cycle, downstream_reset<=all 1, sequence_done<=0, go to RELEASE with idx=0, cnt=0; SETTLE is skipped.
REQ-023 resequence_request is ignored and not acked outside RUN.
REQ-024 lock loss and request in the same cycle: lock loss wins; no ack.
REQ-025 Counter width SHALL be $clog2 of the largest cycle parameter plus 1; no wrap is possible within any state.
REQ-026 Released stages SHALL never re-assert except via REQ-021 or REQ-022, and then all stages re-assert together.

Reset
REQ-027 upstream_reset_n=0: state WAIT_LOCK, downstream_reset all 1, sequence_done 0, resequence_ack 0, pll_reset 0, retry_count 0, all counters and synchronizer flops 0.
REQ-028 Reset mid-sequence SHALL abort immediately (next edge); the sequence restarts from WAIT_LOCK after release.

Configuration
REQ-029 Macro RESET_SEQUENCER_TIMEOUT_EN defined: a timeout counter runs in WAIT_LOCK and SETTLE and clears on entry to RELEASE.
  - At TIMEOUT_CYCLES-1 the block enters PLL_RST: pll_reset=1 for PLL_RESET_CYCLES and retry_count increments (saturating).
  - It then returns to WAIT_LOCK.
REQ-030 Macro absent: no timeout logic; pll_reset and retry_count are tied to 0; the ports remain present.

Structure
REQ-031 Package reset_sequencer_pkg holds the state encoding constants and a counter-width function.
REQ-032 One sub-module, sync_2ff (2-flop level synchronizer), is instantiated for pll_locked.

Verification (NUM_STAGES=3, LOCK_STABLE_CYCLES=10, STAGE_DELAY_CYCLES=4, TIMEOUT_CYCLES=50, PLL_RESET_CYCLES=3)
REQ-033 Power-on: reset_n low 5 cycles, pll_locked high from cycle 20.
  - downstream_reset goes 111->110->100->000 at 4-cycle spacing after 10 settle cycles.
  - sequence_done rises with the last release.
REQ-034 Lock glitch: pll_locked low 2 cycles mid-SETTLE -> return to WAIT_LOCK, full 10-cycle settle repeated, no early release.
REQ-035 Lock loss in RUN: pll_locked falls -> downstream_reset=111 and sequence_done=0 within 3 cycles; the sequence reruns on relock.
REQ-036 Resequence in RUN: request held -> one ack pulse, downstream_reset=111 next cycle, releases at 4-cycle spacing with no settle.
  - A request made during RELEASE is not acked until RUN.
REQ-037 Request and lock loss in the same cycle -> no ack, state WAIT_LOCK.
REQ-038 With RESET_SEQUENCER_TIMEOUT_EN and pll_locked stuck low: pll_reset high 3 cycles at cycle 50 and retry_count=1, repeating each 53 cycles.
  - Without the macro, pll_reset stays 0.
